// File: rtl/csr_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit_if
// Description : EX-stage to CSR-unit request/response bundle.
// Revision    : 1.0
// ============================================================================
interface csr_unit_if;
   logic [31:0] pc;
   logic [11:0] csr_addr;
   logic [31:0] rs1_rdata;
   logic        wr;
   logic        set;
   logic        clr;
   logic        reg_wr;
   logic        mret;
   logic        wfi;
   logic [31:0] rd_wdata;

   modport master (
      output pc, csr_addr, rs1_rdata, wr, set, clr, reg_wr, mret, wfi,
      input  rd_wdata
   );

   modport slave (
      input  pc, csr_addr, rs1_rdata, wr, set, clr, reg_wr, mret, wfi,
      output rd_wdata
   );
endinterface
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit
// Description : Machine-mode CSRs, 64-bit counters, interrupts, MRET and WFI.
// Revision    : 1.0
// ============================================================================
module csr_unit #(
   parameter logic [31:0] MTVEC_ADDR = 32'h0001_0000
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        cpuwait_i,
   input  wire logic        retire_i,
   input  wire logic        ext_irq_i,
   input  wire logic        timer_irq_i,
   csr_unit_if.slave        ex2csr,
   output logic             redirect_o,
   output logic [31:0]      redirect_pc_o,
   output logic             stall_o
);
   localparam logic [11:0] c_mstatus   = 12'h300;
   localparam logic [11:0] c_mie       = 12'h304;
   localparam logic [11:0] c_mtvec     = 12'h305;
   localparam logic [11:0] c_mepc      = 12'h341;
   localparam logic [11:0] c_mip       = 12'h344;
   localparam logic [11:0] c_mcycle    = 12'hB00;
   localparam logic [11:0] c_mcycleh   = 12'hB80;
   localparam logic [11:0] c_minstret  = 12'hB02;
   localparam logic [11:0] c_minstreth = 12'hB82;
   localparam logic [11:0] c_cycle     = 12'hC00;
   localparam logic [11:0] c_cycleh    = 12'hC80;
   localparam logic [11:0] c_instret   = 12'hC02;
   localparam logic [11:0] c_instreth  = 12'hC82;

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_SLEEP = 1'b1} state_t;

   state_t      r_state;
   logic        r_mie;
   logic        r_mpie;
   logic        r_mtie;
   logic        r_meie;
   logic [31:0] r_mepc;
   logic [31:0] r_wfi_pc;
   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;

   logic [31:0] w_mstatus;
   logic [31:0] w_mie_csr;
   logic [31:0] w_mip;
   logic [31:0] w_rdata;
   logic [31:0] w_wval;
   logic        w_pending;
   logic        w_sleep;
   logic        w_trap;
   logic        w_mret;
   logic        w_we;
   logic        w_unused;

   assign w_unused  = ex2csr.reg_wr;

   assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
   assign w_mie_csr = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
   assign w_mip     = {20'b0, ext_irq_i, 3'b0, timer_irq_i, 7'b0};

   always_comb begin
      w_rdata = 32'b0;
      case (ex2csr.csr_addr)
         c_mstatus:              w_rdata = w_mstatus;
         c_mie:                  w_rdata = w_mie_csr;
         c_mtvec:                w_rdata = MTVEC_ADDR;
         c_mepc:                 w_rdata = r_mepc;
         c_mip:                  w_rdata = w_mip;
         c_mcycle,   c_cycle:    w_rdata = r_mcycle[31:0];
         c_mcycleh,  c_cycleh:   w_rdata = r_mcycle[63:32];
         c_minstret, c_instret:  w_rdata = r_minstret[31:0];
         c_minstreth, c_instreth: w_rdata = r_minstret[63:32];
         default:                w_rdata = 32'b0;
      endcase
   end
   assign ex2csr.rd_wdata = w_rdata;

   assign w_pending = |(w_mip & w_mie_csr);
   assign w_sleep   = (r_state == ST_SLEEP);
   assign w_trap    = r_mie & w_pending & ~cpuwait_i;
   // While sleeping the pipeline is frozen, so the EX slot issues no CSR side effects.
   assign w_mret    = ex2csr.mret & ~w_trap & ~cpuwait_i & ~w_sleep;
   assign w_we      = (ex2csr.wr | ex2csr.set | ex2csr.clr) & ~w_trap & ~cpuwait_i & ~w_sleep;

   always_comb begin
      w_wval = ex2csr.rs1_rdata;
      if (ex2csr.set)
         w_wval = w_rdata | ex2csr.rs1_rdata;
      else if (ex2csr.clr)
         w_wval = w_rdata & ~ex2csr.rs1_rdata;
   end

   assign redirect_o = w_trap | w_mret;
   assign stall_o    = w_sleep & ~w_pending;

   always_comb begin
      redirect_pc_o = 32'b0;
      if (w_trap)
         redirect_pc_o = MTVEC_ADDR;
      else if (w_mret)
         redirect_pc_o = r_mepc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_RUN;
         r_mie    <= 1'b0;
         r_mpie   <= 1'b0;
         r_mtie   <= 1'b0;
         r_meie   <= 1'b0;
         r_mepc   <= 32'b0;
         r_wfi_pc <= 32'b0;
      end else begin
         if (w_trap) begin
            r_mepc <= w_sleep ? {r_wfi_pc[31:2] + 30'd1, 2'b00} : {ex2csr.pc[31:2], 2'b00};
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
         end else if (w_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
         end else if (w_we) begin
            case (ex2csr.csr_addr)
               c_mstatus: begin
                  r_mie  <= w_wval[3];
                  r_mpie <= w_wval[7];
               end
               c_mie: begin
                  r_mtie <= w_wval[7];
                  r_meie <= w_wval[11];
               end
               c_mepc:  r_mepc <= {w_wval[31:2], 2'b00};
               default: ;
            endcase
         end

         case (r_state)
            ST_RUN: begin
               if (ex2csr.wfi & ~w_pending & ~cpuwait_i) begin
                  r_state  <= ST_SLEEP;
                  r_wfi_pc <= ex2csr.pc;
               end
            end
            ST_SLEEP: begin
               if (w_pending & ~cpuwait_i)
                  r_state <= ST_RUN;
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   // A write to either half replaces that cycle's increment of the whole counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcycle   <= 64'b0;
         r_minstret <= 64'b0;
      end else begin
         if (w_we && ex2csr.csr_addr == c_mcycle)
            r_mcycle[31:0] <= w_wval;
         else if (w_we && ex2csr.csr_addr == c_mcycleh)
            r_mcycle[63:32] <= w_wval;
         else
            r_mcycle <= r_mcycle + 64'd1;

         if (w_we && ex2csr.csr_addr == c_minstret)
            r_minstret[31:0] <= w_wval;
         else if (w_we && ex2csr.csr_addr == c_minstreth)
            r_minstret[63:32] <= w_wval;
         else if (retire_i & ~cpuwait_i)
            r_minstret <= r_minstret + 64'd1;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_unit
// Description : Directed and randomized checks of csr_unit against a CSR model.
// Revision    : 1.0
// ============================================================================
module tb_csr_unit;
   localparam logic [31:0] MTVEC = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpuwait_i = 1'b0;
   logic        retire_i = 1'b0;
   logic        ext_irq_i = 1'b0;
   logic        timer_irq_i = 1'b0;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        stall_o;

   csr_unit_if bus();

   csr_unit #(.MTVEC_ADDR(MTVEC)) dut (
      .clk          (clk),
      .rst          (rst),
      .cpuwait_i    (cpuwait_i),
      .retire_i     (retire_i),
      .ext_irq_i    (ext_irq_i),
      .timer_irq_i  (timer_irq_i),
      .ex2csr       (bus),
      .redirect_o   (redirect_o),
      .redirect_pc_o(redirect_pc_o),
      .stall_o      (stall_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [11:0] c_addrs [0:15] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h344, 12'hB00,
                                   12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                                   12'hC82, 12'h301, 12'h7C0, 12'hF14};

   // Reference model state
   bit          m_mie, m_mpie, m_mtie, m_meie, m_sleep;
   logic [31:0] m_mepc, m_wfi_pc;
   logic [63:0] m_mcycle, m_minstret;

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0; m_sleep = 0;
      m_mepc = 0; m_wfi_pc = 0; m_mcycle = 0; m_minstret = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
         12'h304: return (m_meie ? 32'h800 : 32'h0) | (m_mtie ? 32'h80 : 32'h0);
         12'h305: return MTVEC;
         12'h341: return m_mepc;
         12'h344: return (ext_irq_i ? 32'h800 : 32'h0) | (timer_irq_i ? 32'h80 : 32'h0);
         12'hB00, 12'hC00: return m_mcycle[31:0];
         12'hB80, 12'hC80: return m_mcycle[63:32];
         12'hB02, 12'hC02: return m_minstret[31:0];
         12'hB82, 12'hC82: return m_minstret[63:32];
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit f_pend();
      return (timer_irq_i && m_mtie) || (ext_irq_i && m_meie);
   endfunction
   function automatic bit f_trap();
      return m_mie && f_pend() && !cpuwait_i;
   endfunction
   function automatic bit f_mret();
      return bus.mret && !f_trap() && !cpuwait_i && !m_sleep;
   endfunction
   function automatic logic [31:0] f_redirect_pc();
      return f_trap() ? MTVEC : (f_mret() ? m_mepc : 32'h0);
   endfunction

   task automatic model_step();
      bit pend, trap, mret_ok, we;
      logic [31:0] old, nv;
      logic [63:0] cyc0, ins0;
      pend    = f_pend();
      trap    = f_trap();
      mret_ok = f_mret();
      we      = (bus.wr || bus.set || bus.clr) && !trap && !cpuwait_i && !m_sleep;
      old     = m_read(bus.csr_addr);
      nv      = bus.wr ? bus.rs1_rdata : (bus.set ? (old | bus.rs1_rdata) : (old & ~bus.rs1_rdata));
      cyc0    = m_mcycle;
      ins0    = m_minstret;
      m_mcycle = cyc0 + 64'd1;
      if (retire_i && !cpuwait_i) m_minstret = ins0 + 64'd1;
      if (we) begin
         case (bus.csr_addr)
            12'h300: if (!mret_ok) begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: begin m_mtie = nv[7]; m_meie = nv[11]; end
            12'h341: m_mepc = nv & 32'hFFFF_FFFC;
            12'hB00: m_mcycle   = {cyc0[63:32], nv};
            12'hB80: m_mcycle   = {nv, cyc0[31:0]};
            12'hB02: m_minstret = {ins0[63:32], nv};
            12'hB82: m_minstret = {nv, ins0[31:0]};
            default: ;
         endcase
      end
      if (trap) begin
         m_mepc = (m_sleep ? m_wfi_pc + 32'd4 : bus.pc) & 32'hFFFF_FFFC;
         m_mpie = m_mie;
         m_mie  = 0;
      end else if (mret_ok) begin
         m_mie  = m_mpie;
         m_mpie = 1;
      end
      if (!m_sleep) begin
         if (bus.wfi && !pend && !cpuwait_i) begin m_sleep = 1; m_wfi_pc = bus.pc; end
      end else if (pend && !cpuwait_i) begin
         m_sleep = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
   endtask

   task automatic idle_bus();
      bus.pc = 32'h0; bus.csr_addr = 12'h0; bus.rs1_rdata = 32'h0;
      bus.wr = 0; bus.set = 0; bus.clr = 0; bus.reg_wr = 0; bus.mret = 0; bus.wfi = 0;
   endtask

   // kind: 0 read only, 1 CSRRW, 2 CSRRS, 3 CSRRC
   task automatic op(input logic [11:0] a, input logic [31:0] v, input int kind);
      idle_bus();
      bus.csr_addr = a; bus.rs1_rdata = v;
      bus.wr = (kind == 1); bus.set = (kind == 2); bus.clr = (kind == 3);
      bus.reg_wr = (kind != 0);
   endtask

   task automatic test_reset();
      idle_bus();
      model_reset();
      #2;
      checks++;
      if (stall_o !== 1'b0 || redirect_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got stall=%b redir=%b pc=%h exp 0/0/0", stall_o, redirect_o, redirect_pc_o);
      end
      for (int i = 0; i < 16; i++) begin
         bus.csr_addr = c_addrs[i];
         #1;
         checks++;
         if (bus.rd_wdata !== m_read(c_addrs[i])) begin
            errors++;
            $display("FAIL reset_read addr=%h got %h exp %h", c_addrs[i], bus.rd_wdata, m_read(c_addrs[i]));
         end
      end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_mstatus();
      op(12'h300, 32'h8, 1); #1;
      checks++;
      if (bus.rd_wdata !== 32'h1800) begin
         errors++; $display("FAIL mstatus_rw_old got %h exp %h", bus.rd_wdata, 32'h1800);
      end
      tick();
      op(12'h300, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h1808 || bus.rd_wdata !== m_read(12'h300)) begin
         errors++; $display("FAIL mstatus_rw_new got %h exp %h", bus.rd_wdata, 32'h1808);
      end
      tick();
      op(12'h300, 32'h8, 3); tick();
      op(12'h300, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h1800) begin
         errors++; $display("FAIL mstatus_rc got %h exp %h", bus.rd_wdata, 32'h1800);
      end
      tick();
   endtask

   task automatic test_counters();
      op(12'hB00, 32'hFFFF_FFFF, 1); tick();
      idle_bus(); tick(); tick();
      op(12'hB80, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h1) begin
         errors++; $display("FAIL mcycleh_wrap got %h exp %h", bus.rd_wdata, 32'h1);
      end
      op(12'hB00, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h1) begin
         errors++; $display("FAIL mcycle_wrap got %h exp %h", bus.rd_wdata, 32'h1);
      end
      tick();
      retire_i = 1;
      op(12'hB02, 32'hFFFF_FFFF, 1); tick();
      idle_bus(); tick(); tick();
      op(12'hC82, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h1) begin
         errors++; $display("FAIL instreth_wrap got %h exp %h", bus.rd_wdata, 32'h1);
      end
      op(12'hB02, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h1) begin
         errors++; $display("FAIL instret_wrap got %h exp %h", bus.rd_wdata, 32'h1);
      end
      retire_i = 0;
      op(12'hB82, 32'h0, 1); tick();
      op(12'hB02, 32'hFFFF_FFFF, 1); tick();
      cpuwait_i = 1; retire_i = 1;
      op(12'hB02, 32'h1234, 1); tick(); tick();
      op(12'hB02, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL instret_cpuwait got %h exp %h", bus.rd_wdata, 32'hFFFF_FFFF);
      end
      op(12'hC00, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== m_read(12'hC00)) begin
         errors++; $display("FAIL mcycle_cpuwait got %h exp %h", bus.rd_wdata, m_read(12'hC00));
      end
      cpuwait_i = 0; retire_i = 0;
      tick();
   endtask

   task automatic test_trap();
      op(12'h304, 32'h800, 1); tick();
      op(12'h300, 32'h8, 2); tick();
      ext_irq_i = 1;
      op(12'h341, 32'h5555, 1); bus.pc = 32'h120; #1;
      checks++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== MTVEC) begin
         errors++; $display("FAIL trap_redirect got %b/%h exp 1/%h", redirect_o, redirect_pc_o, MTVEC);
      end
      tick();
      op(12'h341, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h120 || redirect_o !== 1'b0) begin
         errors++; $display("FAIL trap_mepc got %h redir=%b exp %h redir=0", bus.rd_wdata, redirect_o, 32'h120);
      end
      op(12'h300, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h1880) begin
         errors++; $display("FAIL trap_mstatus got %h exp %h", bus.rd_wdata, 32'h1880);
      end
      ext_irq_i = 0;
      tick();
   endtask

   task automatic test_mret();
      op(12'h341, 32'h200, 1); tick();
      op(12'h300, 32'h80, 1); tick();
      idle_bus(); bus.mret = 1; #1;
      checks++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h200) begin
         errors++; $display("FAIL mret_redirect got %b/%h exp 1/%h", redirect_o, redirect_pc_o, 32'h200);
      end
      tick();
      op(12'h300, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h1888) begin
         errors++; $display("FAIL mret_mstatus got %h exp %h", bus.rd_wdata, 32'h1888);
      end
      op(12'h300, 32'h0, 1); tick();
   endtask

   task automatic test_wfi();
      op(12'h304, 32'h80, 1); tick();
      op(12'h300, 32'h8, 1); tick();
      idle_bus(); bus.pc = 32'h300; bus.wfi = 1; #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL wfi_accept_stall got %b exp 0", stall_o);
      end
      tick();
      idle_bus(); bus.pc = 32'h304; tick();
      checks++;
      if (stall_o !== 1'b1) begin
         errors++; $display("FAIL wfi_sleep_stall got %b exp 1", stall_o);
      end
      timer_irq_i = 1; #1;
      checks++;
      if (stall_o !== 1'b0 || redirect_o !== 1'b1 || redirect_pc_o !== MTVEC) begin
         errors++; $display("FAIL wfi_wake_trap got stall=%b redir=%b pc=%h exp 0/1/%h", stall_o, redirect_o, redirect_pc_o, MTVEC);
      end
      tick();
      op(12'h341, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h304) begin
         errors++; $display("FAIL wfi_mepc got %h exp %h", bus.rd_wdata, 32'h304);
      end
      timer_irq_i = 0;
      op(12'h300, 32'h0, 1); tick();
      idle_bus(); bus.pc = 32'h400; bus.wfi = 1; tick();
      idle_bus(); #1;
      checks++;
      if (stall_o !== 1'b1) begin
         errors++; $display("FAIL wfi2_stall got %b exp 1", stall_o);
      end
      timer_irq_i = 1; #1;
      checks++;
      if (stall_o !== 1'b0 || redirect_o !== 1'b0) begin
         errors++; $display("FAIL wfi2_wake got stall=%b redir=%b exp 0/0", stall_o, redirect_o);
      end
      tick();
      op(12'h341, 32'h0, 0); #1;
      checks++;
      if (stall_o !== 1'b0 || bus.rd_wdata !== 32'h304) begin
         errors++; $display("FAIL wfi2_resume got stall=%b mepc=%h exp 0/%h", stall_o, bus.rd_wdata, 32'h304);
      end
      timer_irq_i = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      idle_bus(); bus.pc = 32'h500; bus.wfi = 1; tick();
      idle_bus(); #1;
      checks++;
      if (stall_o !== 1'b1) begin
         errors++; $display("FAIL rst_pre_sleep got %b exp 1", stall_o);
      end
      rst = 1; model_reset(); #1;
      checks++;
      if (stall_o !== 1'b0 || redirect_o !== 1'b0) begin
         errors++; $display("FAIL rst_sleep_outputs got stall=%b redir=%b exp 0/0", stall_o, redirect_o);
      end
      for (int i = 0; i < 13; i++) begin
         bus.csr_addr = c_addrs[i]; #1;
         checks++;
         if (bus.rd_wdata !== m_read(c_addrs[i])) begin
            errors++; $display("FAIL rst_sleep_read addr=%h got %h exp %h", c_addrs[i], bus.rd_wdata, m_read(c_addrs[i]));
         end
      end
      @(negedge clk); rst = 0;
      op(12'hB00, 32'hABCD, 1); tick();
      cpuwait_i = 1; op(12'h300, 32'h8, 1); #1;
      rst = 1; model_reset(); #1;
      op(12'hB00, 32'h0, 0); #1;
      checks++;
      if (bus.rd_wdata !== 32'h0 || stall_o !== 1'b0 || redirect_o !== 1'b0) begin
         errors++; $display("FAIL rst_cpuwait got mcycle=%h stall=%b redir=%b exp 0/0/0", bus.rd_wdata, stall_o, redirect_o);
      end
      @(negedge clk); rst = 0; cpuwait_i = 0;
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         int sel;
         idle_bus();
         sel = int'($urandom_range(0, 19));
         if (sel < 14) begin
            op(c_addrs[$urandom_range(0, 15)], $urandom, int'($urandom_range(0, 3)));
         end else if (sel < 16) begin
            bus.mret = 1;
         end else if (sel < 18) begin
            bus.wfi = 1;
         end
         bus.pc      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         ext_irq_i   = ($urandom_range(0, 7) == 0);
         timer_irq_i = ($urandom_range(0, 7) == 0);
         cpuwait_i   = ($urandom_range(0, 5) == 0);
         retire_i    = $urandom_range(0, 1) != 0;
         #1;
         checks++;
         if (bus.rd_wdata !== m_read(bus.csr_addr) || redirect_o !== (f_trap() || f_mret()) ||
             redirect_pc_o !== f_redirect_pc() || stall_o !== (m_sleep && !f_pend())) begin
            errors++;
            $display("FAIL random n=%0d addr=%h rd=%h/%h redir=%b/%b pc=%h/%h stall=%b/%b", n, bus.csr_addr,
                     bus.rd_wdata, m_read(bus.csr_addr), redirect_o, f_trap() || f_mret(),
                     redirect_pc_o, f_redirect_pc(), stall_o, m_sleep && !f_pend());
         end
         tick();
      end
      idle_bus(); ext_irq_i = 0; timer_irq_i = 0; cpuwait_i = 0; retire_i = 0;
   endtask

   initial begin
      test_reset();
      test_mstatus();
      test_counters();
      test_trap();
      test_mret();
      test_wfi();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
